sp_sram_banked_ctrl: RTL and testbench
======================================

# sp_sram_banked_ctrl

Parametrised, bank-interleaved single-port SRAM controller replacing the fixed 4096x128 bank wrapper in the memory subsystem. It accepts one request per cycle on a valid/ready interface and steers the request to one of NUM_BANKS word-interleaved banks with per-byte write enables. Read data returns with a tag on a back-pressurable response port. An optional zero-initialisation sweep runs after reset.

## Interface
Parameters:
- DW, 128: data width in bits; multiple of 8.
- AW, 14: word address width; total depth 2**AW words.
- NUM_BANKS, 4: bank count; power of 2, 1..16, at most 2**AW.
- ID_W, 4: request tag width.
- ZERO_INIT, 1: 1 = sweep all banks to zero after reset; 0 = no sweep, contents undefined.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid and ready are both high.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  AW  word address.
- req_be_i  in  DW/8  byte enables; writes only.
- req_wdata_i  in  DW  write data.
- req_id_i  in  ID_W  tag; returned on reads.
- rsp_valid_o  out  1  read response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_rdata_o  out  DW  read data.
- rsp_id_o  out  ID_W  tag of the returned read.
- init_done_o  out  1  high once the controller accepts requests.

## Operation
- Bank select is req_addr_i[log2(NUM_BANKS)-1:0]. Row is req_addr_i[AW-1:log2(NUM_BANKS)]. Each bank holds 2**AW/NUM_BANKS words of DW bits.
- Each bank is a synchronous-read array. Exactly one bank is enabled per accepted request; all other banks stay idle.
- Write: byte i of the selected row is updated only if req_be_i[i]=1. All-zero be: no change. Writes produce no response.
- Read: the row is read into the bank output. The bank index and req_id_i are registered alongside it, and the output mux uses the registered bank index.
- req_ready_o = init_done_o & (~rsp_valid_o | rsp_ready_i). This is combinational from rsp_ready_i.
- While a response is stalled (rsp_valid_o=1 and rsp_ready_i=0):
  - rsp_rdata_o and rsp_id_o stay stable.
  - No bank is enabled, so bank outputs hold.
- FSM, states INIT then RUN:
  - On reset, enter INIT if ZERO_INIT=1, otherwise RUN.
  - In INIT, a row counter steps 0..2**AW/NUM_BANKS-1. Each cycle it writes zero to that row in all banks in parallel, with all bytes enabled.
  - After the last row, transition to RUN.
  - In RUN, init_done_o=1 and requests are served.
- Reset asserted mid-INIT or mid-RUN:
  - The FSM restarts from row 0 (ZERO_INIT=1).
  - Any pending response is dropped.
  - Contents are not otherwise cleared.

## Timing
- Reset values: req_ready_o=0 during INIT. rsp_valid_o=0. rsp_rdata_o=0. rsp_id_o=0. init_done_o=ZERO_INIT?0:1.
- Init duration: 2**AW/NUM_BANKS cycles after rst deasserts. init_done_o rises on the cycle after the last sweep write (default 4096 cycles).
- Read latency:
  - A read accepted at edge N gives rsp_valid_o=1 with data after edge N+1.
  - The response holds until rsp_ready_i=1 is sampled.
- Throughput: one request per cycle with no bubbles while rsp_ready_i=1, including back-to-back reads to the same bank.
- Simultaneous response handshake and new read accept: the new response replaces the old one on the next edge, and rsp_valid_o stays 1.
- Write accepted at edge N with no new read at N: rsp_valid_o falls after N if the pending response was consumed at N.
- Read-after-write to the same address on consecutive cycles returns the new data. Only one request exists per cycle, so there is no collision.
- Address wrap: none. The full AW range is valid, and every address maps to exactly one bank/row.

## Test plan
- ZERO_INIT=1, AW=14, NB=4: release rst. init_done_o rises after exactly 4096 cycles. Then read addresses 0, 1, 16383 -> all data 0, with rsp_id_o echoing ids 1, 2, 3.
- Write addr 5 = 0x00..00_DEADBEEF_CAFEF00D with all be, then read addr 5 id 7 -> data matches, id 7, one cycle latency.
- Byte enables:
  - Write 0xFF..FF to addr 9.
  - Write 0x0 to addr 9 with be=0x0001 -> read returns 0xFF..FF00.
  - Write with be=0 -> unchanged.
- Back-pressure:
  - Read addrs 0..3 back-to-back with rsp_ready_i=0 from the second cycle.
  - req_ready_o drops, and the first response holds stable for 10 cycles.
  - Raise rsp_ready_i -> remaining reads complete in order, none lost or duplicated.
- Interleaving: write the address value to addrs 0..63, read them back in random order -> each read returns its own address.
- Reset mid-init at cycle 100 and mid-stall -> rsp_valid_o=0 next cycle, and init restarts with a full 4096-cycle sweep.

Source files
------------

// File: rtl/sp_sram_banked_ctrl_if.sv
// Request/response bundle for the banked single-port SRAM controller.
// Master issues requests and consumes responses; slave is the controller.
interface sp_sram_banked_ctrl_if #(
    parameter int DW   = 128,
    parameter int AW   = 14,
    parameter int ID_W = 4
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [AW-1:0]     req_addr_i;
    logic [DW/8-1:0]   req_be_i;
    logic [DW-1:0]     req_wdata_i;
    logic [ID_W-1:0]   req_id_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DW-1:0]     rsp_rdata_o;
    logic [ID_W-1:0]   rsp_id_o;
    logic              init_done_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_be_i,
        output req_wdata_i, req_id_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_id_o,
        input  init_done_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_be_i,
        input  req_wdata_i, req_id_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_id_o,
        output init_done_o
    );
endinterface

// File: rtl/sp_sram_banked_ctrl.sv
// Word-interleaved single-port SRAM controller with byte enables,
// tagged read responses and an optional zero sweep after reset.
module sp_sram_banked_ctrl #(
    parameter int DW        = 128,
    parameter int AW        = 14,
    parameter int NUM_BANKS = 4,
    parameter int ID_W      = 4,
    parameter int ZERO_INIT = 1
) (
    input logic                 clk,
    input logic                 rst,
    sp_sram_banked_ctrl_if.slave bus
);
    localparam int NBE  = DW / 8;
    localparam int LB   = $clog2(NUM_BANKS);
    localparam int BW   = (LB > 0) ? LB : 1;
    localparam int RW   = (AW > LB) ? (AW - LB) : 1;
    localparam int ROWS = (2 ** AW) / NUM_BANKS;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [RW-1:0]    init_row;
    logic [RW-1:0]    init_row_nxt;

    logic             init_done;
    logic             accept;
    logic [BW-1:0]    req_bank;
    logic [RW-1:0]    req_row;

    logic [NUM_BANKS-1:0] bank_en;
    logic                 mem_we;
    logic [RW-1:0]        mem_row;
    logic [NBE-1:0]       mem_be;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        bank_q [NUM_BANKS];

    logic             rsp_valid;
    logic [ID_W-1:0]  rsp_id;
    logic [BW-1:0]    rsp_bank;

    assign init_done = (state == RUN);
    assign req_bank  = BW'(bus.req_addr_i & AW'(NUM_BANKS - 1));
    assign req_row   = RW'(bus.req_addr_i >> LB);

    assign bus.init_done_o = init_done;
    assign bus.req_ready_o = init_done & (~rsp_valid | bus.rsp_ready_i);
    assign accept          = bus.req_valid_i & bus.req_ready_o;

    // State and sweep-row register; reset restarts the sweep from row 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= (ZERO_INIT != 0) ? INIT : RUN;
            init_row <= '0;
        end else begin
            state    <= state_nxt;
            init_row <= init_row_nxt;
        end
    end

    // Sweep steps one row per cycle and hands over to RUN after the last.
    always_comb begin
        state_nxt    = state;
        init_row_nxt = init_row;
        case (state)
            INIT: begin
                init_row_nxt = init_row + 1'b1;
                if (init_row == RW'(ROWS - 1)) begin
                    state_nxt    = RUN;
                    init_row_nxt = '0;
                end
            end
            RUN: ;
            default: state_nxt = RUN;
        endcase
    end

    // Bank port steering: all banks write zero while sweeping, else one bank.
    always_comb begin
        bank_en   = '0;
        mem_we    = 1'b0;
        mem_row   = req_row;
        mem_be    = bus.req_be_i;
        mem_wdata = bus.req_wdata_i;
        if (state == INIT) begin
            bank_en   = '1;
            mem_we    = 1'b1;
            mem_row   = init_row;
            mem_be    = '1;
            mem_wdata = '0;
        end else if (accept) begin
            mem_we = bus.req_we_i;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_en[b] = (req_bank == BW'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DW-1:0] mem [ROWS];
        logic [DW-1:0] q;

        // Synchronous-read array; output only moves on an enabled read.
        always_ff @(posedge clk) begin
            if (bank_en[b]) begin
                if (mem_we) begin
                    for (int i = 0; i < NBE; i++) begin
                        if (mem_be[i]) begin
                            mem[mem_row][i*8 +: 8] <= mem_wdata[i*8 +: 8];
                        end
                    end
                end else begin
                    q <= mem[mem_row];
                end
            end
        end

        assign bank_q[b] = q;
    end

    // Response slot: a new read replaces it, a handshake alone empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_bank  <= '0;
        end else if (accept && !bus.req_we_i) begin
            rsp_valid <= 1'b1;
            rsp_id    <= bus.req_id_i;
            rsp_bank  <= req_bank;
        end else if (bus.rsp_ready_i) begin
            rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_id_o    = rsp_id;
    assign bus.rsp_rdata_o = rsp_valid ? bank_q[rsp_bank] : '0;

endmodule

// File: tb/tb_sp_sram_banked_ctrl.sv
// Scoreboard bench for the banked SRAM controller: reads push expected
// data/tag when accepted, a monitor pops them on each response handshake.
module tb_sp_sram_banked_ctrl;
    localparam int DW = 128;
    localparam int AW = 14;
    localparam int NB = 4;
    localparam int IW = 4;
    localparam int SWEEP = (2 ** AW) / NB;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    exp_t sbq [$];
    logic [DW-1:0] mdl [logic [AW-1:0]];

    sp_sram_banked_ctrl_if #(.DW(DW), .AW(AW), .ID_W(IW)) bus ();

    sp_sram_banked_ctrl #(
        .DW(DW), .AW(AW), .NUM_BANKS(NB), .ID_W(IW), .ZERO_INIT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
        return mdl.exists(a) ? mdl[a] : '0;
    endfunction

    task automatic mwrite(input logic [AW-1:0] a, input logic [DW/8-1:0] be,
                          input logic [DW-1:0] d);
        logic [DW-1:0] v;
        v = mread(a);
        for (int i = 0; i < DW / 8; i++)
            if (be[i]) v[i*8 +: 8] = d[i*8 +: 8];
        mdl[a] = v;
    endtask

    // Response monitor: each handshake pops and checks one expected read.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_data", bus.rsp_rdata_o, e.d);
                chk("rsp_id", DW'(bus.rsp_id_o), DW'(e.id));
            end
        end
    end

    task automatic idle();
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
    endtask

    // Present one request and hold it until the edge that accepts it.
    task automatic do_req(input logic we, input logic [AW-1:0] a,
                          input logic [DW/8-1:0] be, input logic [DW-1:0] d,
                          input logic [IW-1:0] id);
        exp_t e;
        int n;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = a;
        bus.req_be_i    = be;
        bus.req_wdata_i = d;
        bus.req_id_i    = id;
        #1;
        n = 0;
        while (!bus.req_ready_o && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!bus.req_ready_o) begin
            chk("req_timeout", 0, 1);
            idle();
        end else begin
            if (we) begin
                mwrite(a, be, d);
            end else begin
                e.id = id;
                e.d  = mread(a);
                sbq.push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_rsp_valid", DW'(bus.rsp_valid_o), 0);
        chk("rst_rsp_rdata", bus.rsp_rdata_o, 0);
        chk("rst_rsp_id", DW'(bus.rsp_id_o), 0);
        chk("rst_init_done", DW'(bus.init_done_o), 0);
        chk("rst_req_ready", DW'(bus.req_ready_o), 0);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!bus.init_done_o && n < SWEEP + 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, DW'(n), DW'(SWEEP));
        mdl.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", DW'(sbq.size()), 0);
    endtask

    initial begin
        int ord [64];
        int j, t;
        logic [DW-1:0] ones;
        logic [DW-1:0] v0;

        ones = '1;
        idle();
        bus.req_addr_i  = '0;
        bus.req_be_i    = '0;
        bus.req_wdata_i = '0;
        bus.req_id_i    = '0;
        bus.rsp_ready_i = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        wait_init("init_cycles");
        chk("run_req_ready", DW'(bus.req_ready_o), 1);

        do_req(0, 14'd0, '0, '0, 4'd1);
        do_req(0, 14'd1, '0, '0, 4'd2);
        do_req(0, 14'd16383, '0, '0, 4'd3);
        idle();
        drain();

        do_req(1, 14'd5, '1, 128'hDEADBEEF_CAFEF00D, 4'd0);
        do_req(0, 14'd5, '0, '0, 4'd7);
        idle();
        chk("lat_valid", DW'(bus.rsp_valid_o), 1);
        chk("lat_data", bus.rsp_rdata_o, 128'hDEADBEEF_CAFEF00D);
        chk("lat_id", DW'(bus.rsp_id_o), 7);
        drain();

        do_req(1, 14'd9, '1, ones, 4'd0);
        do_req(1, 14'd9, 16'h0001, '0, 4'd0);
        do_req(0, 14'd9, '0, '0, 4'd4);
        do_req(1, 14'd9, 16'h0000, '0, 4'd0);
        do_req(0, 14'd9, '0, '0, 4'd5);
        idle();
        drain();

        v0 = mread(14'd0);
        do_req(0, 14'd0, '0, '0, 4'd8);
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 14'd1;
        #1;
        chk("bp_req_ready", DW'(bus.req_ready_o), 0);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", DW'(bus.rsp_valid_o), 1);
            chk("bp_hold_data", bus.rsp_rdata_o, v0);
            chk("bp_hold_id", DW'(bus.rsp_id_o), 8);
        end
        bus.rsp_ready_i = 1'b1;
        do_req(0, 14'd1, '0, '0, 4'd9);
        do_req(0, 14'd2, '0, '0, 4'd10);
        do_req(0, 14'd3, '0, '0, 4'd11);
        idle();
        drain();

        for (int i = 0; i < 64; i++) begin
            do_req(1, AW'(i), '1, DW'(i), 4'd0);
            ord[i] = i;
        end
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
        end
        for (int i = 0; i < 64; i++)
            do_req(0, AW'(ord[i]), '0, '0, IW'(i));
        idle();
        drain();

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        repeat (100) @(posedge clk);
        #1;
        chk("midinit_done", DW'(bus.init_done_o), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        wait_init("reinit_cycles");

        bus.rsp_ready_i = 1'b0;
        do_req(0, 14'd5, '0, '0, 4'd12);
        idle();
        chk("stall_valid", DW'(bus.rsp_valid_o), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sbq.delete();
        chk("stall_rst_valid", DW'(bus.rsp_valid_o), 0);
        bus.rsp_ready_i = 1'b1;
        rst = 1'b0;
        wait_init("stall_reinit_cycles");
        do_req(0, 14'd5, '0, '0, 4'd13);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
